// File: rtl/digit_lock_ctrl_if.sv
// rtl/digit_lock_ctrl_if.sv - strobe/digit inputs and status outputs of the digit lock controller
interface digit_lock_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_TRIES  = 3
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(MAX_TRIES + 1);

  logic                          ent;
  logic                          clr;
  logic                          change;
  logic                          lock;
  logic [DIGIT_W-1:0]            sw;
  logic                          unlocked;
  logic                          locked_out;
  logic [2:0]                    state;
  logic [IW-1:0]                 digit_idx;
  logic [NUM_DIGITS*DIGIT_W-1:0] entry_buf;
  logic [FW-1:0]                 fail_cnt;
  logic                          ok_p;
  logic                          err_p;

  modport master (
    output ent, clr, change, lock, sw,
    input  unlocked, locked_out, state, digit_idx, entry_buf, fail_cnt, ok_p, err_p
  );

  modport slave (
    input  ent, clr, change, lock, sw,
    output unlocked, locked_out, state, digit_idx, entry_buf, fail_cnt, ok_p, err_p
  );
endinterface

// File: rtl/digit_lock_ctrl.sv
// rtl/digit_lock_ctrl.sv - N-digit lock FSM with lockout, relock and code change (DIGIT_LOCK_CONFIRM_EN adds confirm step)
module digit_lock_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
  input logic              clk,
  input logic              rst,
  digit_lock_ctrl_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int CW = NUM_DIGITS * DIGIT_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_NEW     = 3'd4,
    S_CONFIRM = 3'd5,
    S_LOCKOUT = 3'd6
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] code_q, code_n;
  logic [CW-1:0] entry_q, entry_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [FW-1:0] fail_q, fail_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          ok_q, ok_n;
  logic          err_q, err_n;
  logic [CW-1:0] captured;
  logic [FW-1:0] fail_inc;
  logic          last;
  logic          a_clr, a_lock, a_change, a_ent;
`ifdef DIGIT_LOCK_CONFIRM_EN
  logic [CW-1:0] pending_q, pending_n;
`endif

  // One strobe acts per cycle: clr > lock > change > ent
  assign a_clr    = bus.clr;
  assign a_lock   = bus.lock & ~bus.clr;
  assign a_change = bus.change & ~bus.lock & ~bus.clr;
  assign a_ent    = bus.ent & ~bus.change & ~bus.lock & ~bus.clr;
  assign last     = (idx_q == IW'(NUM_DIGITS - 1));
  assign fail_inc = fail_q + FW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      code_q  <= DEFAULT_CODE;
      entry_q <= '0;
      idx_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DIGIT_LOCK_CONFIRM_EN
      pending_q <= '0;
`endif
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      entry_q <= entry_n;
      idx_q   <= idx_n;
      fail_q  <= fail_n;
      timer_q <= timer_n;
      ok_q    <= ok_n;
      err_q   <= err_n;
`ifdef DIGIT_LOCK_CONFIRM_EN
      pending_q <= pending_n;
`endif
    end
  end

  always_comb begin
    captured = entry_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) captured[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = bus.sw;
    end
  end

  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    entry_n = entry_q;
    idx_n   = idx_q;
    fail_n  = fail_q;
    timer_n = timer_q;
    ok_n    = 1'b0;
    err_n   = 1'b0;
`ifdef DIGIT_LOCK_CONFIRM_EN
    pending_n = pending_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (a_ent) begin
          entry_n = captured;
          idx_n   = idx_q + IW'(1);
          state_n = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (a_clr) begin
          entry_n = '0;
          idx_n   = '0;
          state_n = S_IDLE;
        end else if (a_ent) begin
          entry_n = captured;
          if (last) begin
            idx_n   = '0;
            state_n = S_CHECK;
          end else begin
            idx_n = idx_q + IW'(1);
          end
        end
      end
      S_CHECK: begin
        entry_n = '0;
        if (entry_q == code_q) begin
          fail_n  = '0;
          ok_n    = 1'b1;
          state_n = S_OPEN;
        end else begin
          err_n  = 1'b1;
          fail_n = fail_inc;
          if (fail_inc == FW'(MAX_TRIES)) begin
            timer_n = TW'(LOCKOUT_CYCLES - 1);
            state_n = S_LOCKOUT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (a_lock) begin
          state_n = S_IDLE;
        end else if (a_change) begin
          idx_n   = '0;
          state_n = S_NEW;
        end
      end
      S_NEW: begin
        if (a_clr) begin
          entry_n = '0;
          idx_n   = '0;
          state_n = S_OPEN;
        end else if (a_ent) begin
          if (last) begin
            entry_n = '0;
            idx_n   = '0;
`ifdef DIGIT_LOCK_CONFIRM_EN
            pending_n = captured;
            state_n   = S_CONFIRM;
`else
            code_n  = captured;
            ok_n    = 1'b1;
            state_n = S_OPEN;
`endif
          end else begin
            entry_n = captured;
            idx_n   = idx_q + IW'(1);
          end
        end
      end
`ifdef DIGIT_LOCK_CONFIRM_EN
      S_CONFIRM: begin
        if (a_clr) begin
          entry_n   = '0;
          idx_n     = '0;
          pending_n = '0;
          state_n   = S_OPEN;
        end else if (a_ent) begin
          if (last) begin
            entry_n   = '0;
            idx_n     = '0;
            pending_n = '0;
            state_n   = S_OPEN;
            if (captured == pending_q) begin
              code_n = captured;
              ok_n   = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            entry_n = captured;
            idx_n   = idx_q + IW'(1);
          end
        end
      end
`endif
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_n  = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.unlocked   = (state_q == S_OPEN);
  assign bus.locked_out = (state_q == S_LOCKOUT);
  assign bus.digit_idx  = idx_q;
  assign bus.entry_buf  = entry_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.ok_p       = ok_q;
  assign bus.err_p      = err_q;
endmodule

// File: tb/tb_digit_lock_ctrl.sv
// tb/tb_digit_lock_ctrl.sv - directed self-checking bench for digit_lock_ctrl
module tb_digit_lock_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  digit_lock_ctrl_if #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

  digit_lock_ctrl #(
    .NUM_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(16), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic e, input logic c, input logic ch, input logic l, input logic [3:0] d);
    bus.ent = e; bus.clr = c; bus.change = ch; bus.lock = l; bus.sw = d;
    step();
    bus.ent = 1'b0; bus.clr = 1'b0; bus.change = 1'b0; bus.lock = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (bus.unlocked !== 1'b0 || bus.locked_out !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", bus.unlocked, bus.locked_out); end
    checks++; if (bus.entry_buf !== 16'h0 || bus.digit_idx !== 2'd0) begin errors++; $display("FAIL reset_entry: got %h/%0d expected 0000/0", bus.entry_buf, bus.digit_idx); end
    checks++; if (bus.fail_cnt !== 2'd0 || bus.ok_p !== 1'b0 || bus.err_p !== 1'b0) begin errors++; $display("FAIL reset_cnt_pulses: got %0d/%b/%b expected 0/0/0", bus.fail_cnt, bus.ok_p, bus.err_p); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_unlock();
    press(4'd1);
    checks++; if (bus.state !== 3'd1 || bus.digit_idx !== 2'd1 || bus.entry_buf !== 16'h1000) begin errors++; $display("FAIL unlock_first: got %0d/%0d/%h expected 1/1/1000", bus.state, bus.digit_idx, bus.entry_buf); end
    press(4'd2); press(4'd3); press(4'd4);
    checks++; if (bus.state !== 3'd2 || bus.digit_idx !== 2'd0 || bus.entry_buf !== 16'h1234) begin errors++; $display("FAIL unlock_check: got %0d/%0d/%h expected 2/0/1234", bus.state, bus.digit_idx, bus.entry_buf); end
    step();
    checks++; if (bus.state !== 3'd3 || bus.unlocked !== 1'b1 || bus.ok_p !== 1'b1) begin errors++; $display("FAIL unlock_open: got %0d/%b/%b expected 3/1/1", bus.state, bus.unlocked, bus.ok_p); end
    checks++; if (bus.fail_cnt !== 2'd0 || bus.entry_buf !== 16'h0 || bus.err_p !== 1'b0) begin errors++; $display("FAIL unlock_clean: got %0d/%h/%b expected 0/0000/0", bus.fail_cnt, bus.entry_buf, bus.err_p); end
    step();
    checks++; if (bus.ok_p !== 1'b0 || bus.state !== 3'd3) begin errors++; $display("FAIL unlock_pulse_width: got %b/%0d expected 0/3", bus.ok_p, bus.state); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checks++; if (bus.state !== 3'd0 || bus.unlocked !== 1'b0) begin errors++; $display("FAIL relock: got %0d/%b expected 0/0", bus.state, bus.unlocked); end
  endtask

  task automatic test_clr();
    press(4'd1); press(4'd2);
    checks++; if (bus.entry_buf !== 16'h1200 || bus.digit_idx !== 2'd2) begin errors++; $display("FAIL clr_partial: got %h/%0d expected 1200/2", bus.entry_buf, bus.digit_idx); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    checks++; if (bus.state !== 3'd0 || bus.entry_buf !== 16'h0 || bus.digit_idx !== 2'd0) begin errors++; $display("FAIL clr_abort: got %0d/%h/%0d expected 0/0000/0", bus.state, bus.entry_buf, bus.digit_idx); end
    enter_code(16'h1234);
    step();
    checks++; if (bus.state !== 3'd3 || bus.ok_p !== 1'b1) begin errors++; $display("FAIL clr_reentry: got %0d/%b expected 3/1", bus.state, bus.ok_p); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_lockout();
    int n;
    for (int k = 1; k <= 3; k++) begin
      enter_code(16'h1111);
      step();
      checks++; if (bus.err_p !== 1'b1 || bus.ok_p !== 1'b0 || bus.fail_cnt !== 2'(k)) begin errors++; $display("FAIL lockout_try%0d: got err=%b ok=%b cnt=%0d expected 1/0/%0d", k, bus.err_p, bus.ok_p, bus.fail_cnt, k); end
      checks++; if (bus.state !== ((k < 3) ? 3'd0 : 3'd6)) begin errors++; $display("FAIL lockout_state%0d: got %0d expected %0d", k, bus.state, (k < 3) ? 0 : 6); end
    end
    checks++; if (bus.locked_out !== 1'b1) begin errors++; $display("FAIL lockout_flag: got %b expected 1", bus.locked_out); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.state != 3'd6) break;
      n++;
      if (i == 3) press(4'd7); else step();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL lockout_dwell: got %0d cycles expected 16", n); end
    checks++; if (bus.state !== 3'd0 || bus.fail_cnt !== 2'd0 || bus.locked_out !== 1'b0) begin errors++; $display("FAIL lockout_exit: got %0d/%0d/%b expected 0/0/0", bus.state, bus.fail_cnt, bus.locked_out); end
    checks++; if (bus.entry_buf !== 16'h0 || bus.digit_idx !== 2'd0) begin errors++; $display("FAIL lockout_ent_ignored: got %h/%0d expected 0000/0", bus.entry_buf, bus.digit_idx); end
  endtask

  task automatic test_change();
    enter_code(16'h1234);
    step();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++; if (bus.state !== 3'd4 || bus.digit_idx !== 2'd0) begin errors++; $display("FAIL change_enter: got %0d/%0d expected 4/0", bus.state, bus.digit_idx); end
    press(4'd9); press(4'd8); press(4'd7);
    checks++; if (bus.entry_buf !== 16'h9870 || bus.digit_idx !== 2'd3) begin errors++; $display("FAIL change_partial: got %h/%0d expected 9870/3", bus.entry_buf, bus.digit_idx); end
    press(4'd6);
`ifdef DIGIT_LOCK_CONFIRM_EN
    enter_code(16'h9876);
`endif
    checks++; if (bus.state !== 3'd3 || bus.ok_p !== 1'b1 || bus.entry_buf !== 16'h0) begin errors++; $display("FAIL change_commit: got %0d/%b/%h expected 3/1/0000", bus.state, bus.ok_p, bus.entry_buf); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL change_lock: got %0d expected 0", bus.state); end
    enter_code(16'h1234);
    step();
    checks++; if (bus.err_p !== 1'b1 || bus.state !== 3'd0 || bus.fail_cnt !== 2'd1) begin errors++; $display("FAIL change_old_code: got %b/%0d/%0d expected 1/0/1", bus.err_p, bus.state, bus.fail_cnt); end
    enter_code(16'h9876);
    step();
    checks++; if (bus.ok_p !== 1'b1 || bus.state !== 3'd3 || bus.fail_cnt !== 2'd0) begin errors++; $display("FAIL change_new_code: got %b/%0d/%0d expected 1/3/0", bus.ok_p, bus.state, bus.fail_cnt); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_reset_mid_new();
    enter_code(16'h9876);
    step();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    press(4'd1); press(4'd2);
    checks++; if (bus.state !== 3'd4 || bus.entry_buf !== 16'h1200) begin errors++; $display("FAIL midnew_setup: got %0d/%h expected 4/1200", bus.state, bus.entry_buf); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (bus.state !== 3'd0 || bus.unlocked !== 1'b0 || bus.entry_buf !== 16'h0 || bus.digit_idx !== 2'd0) begin errors++; $display("FAIL midnew_reset: got %0d/%b/%h/%0d expected 0/0/0000/0", bus.state, bus.unlocked, bus.entry_buf, bus.digit_idx); end
    checks++; if (bus.fail_cnt !== 2'd0 || bus.ok_p !== 1'b0 || bus.err_p !== 1'b0 || bus.locked_out !== 1'b0) begin errors++; $display("FAIL midnew_outputs: got %0d/%b/%b/%b expected 0/0/0/0", bus.fail_cnt, bus.ok_p, bus.err_p, bus.locked_out); end
    enter_code(16'h1234);
    step();
    checks++; if (bus.state !== 3'd3 || bus.ok_p !== 1'b1) begin errors++; $display("FAIL midnew_default_code: got %0d/%b expected 3/1", bus.state, bus.ok_p); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

`ifdef DIGIT_LOCK_CONFIRM_EN
  task automatic test_confirm();
    enter_code(16'h1234);
    step();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    enter_code(16'h5555);
    checks++; if (bus.state !== 3'd5 || bus.digit_idx !== 2'd0) begin errors++; $display("FAIL confirm_enter: got %0d/%0d expected 5/0", bus.state, bus.digit_idx); end
    enter_code(16'h5556);
    checks++; if (bus.state !== 3'd3 || bus.err_p !== 1'b1 || bus.ok_p !== 1'b0) begin errors++; $display("FAIL confirm_mismatch: got %0d/%b/%b expected 3/1/0", bus.state, bus.err_p, bus.ok_p); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    enter_code(16'h1234);
    step();
    checks++; if (bus.state !== 3'd3 || bus.ok_p !== 1'b1) begin errors++; $display("FAIL confirm_code_kept: got %0d/%b expected 3/1", bus.state, bus.ok_p); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask
`endif

  initial begin
    bus.ent = 1'b0; bus.clr = 1'b0; bus.change = 1'b0; bus.lock = 1'b0; bus.sw = 4'd0;
    test_reset();
    test_unlock();
    test_clr();
    test_lockout();
    test_change();
    test_reset_mid_new();
`ifdef DIGIT_LOCK_CONFIRM_EN
    test_confirm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/digit_lock_ctrl.md
Name: digit_lock_ctrl

Overview:
- Parametrised keypad/switch lock controller, the next generation of the board's 4-digit lock FSM.
- Generalised to N digits of W bits each.
- Adds a failed-attempt counter with timed lockout, an explicit relock input, and a code-change path.
- Sits between the debounced or slow-clocked input logic (`ent`/`clr`/`change`/`lock` strobes plus `sw` digit) and the display/LED drivers.

Parameters:
- NUM_DIGITS, 4, digits per code; must be >= 2.
- DIGIT_W, 4, bits per digit.
- MAX_TRIES, 3, consecutive wrong codes that trigger lockout; must be >= 1.
- LOCKOUT_CYCLES, 16, clk cycles spent in LOCKOUT; must be >= 1.
- DEFAULT_CODE, 0, NUM_DIGITS*DIGIT_W-bit code loaded at reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- ent  in  1  one-cycle strobe: capture `sw` as the current digit.
- clr  in  1  one-cycle strobe: abort the entry in progress.
- change  in  1  one-cycle strobe: begin code change (OPEN only).
- lock  in  1  one-cycle strobe: relock (OPEN only).
- sw  in  DIGIT_W  digit value.
- unlocked  out  1  high while in OPEN.
- locked_out  out  1  high while in LOCKOUT.
- state  out  3  encoding: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, NEW=4, CONFIRM=5, LOCKOUT=6.
- digit_idx  out  clog2(NUM_DIGITS)  index of the next digit to capture.
- entry_buf  out  NUM_DIGITS*DIGIT_W  digits captured so far; first digit in the MSBs; uncaptured digits are 0.
- fail_cnt  out  clog2(MAX_TRIES+1)  consecutive failures.
- ok_p  out  1  one-cycle pulse on successful unlock or code commit.
- err_p  out  1  one-cycle pulse on wrong code or confirm mismatch.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, code=DEFAULT_CODE.
  - entry_buf, digit_idx, fail_cnt, lockout timer = 0.
  - All outputs 0.
- Only one strobe acts per cycle. Priority: clr > lock > change > ent.
- Capture rule (IDLE, ENTRY, NEW, CONFIRM): on ent, entry_buf slot digit_idx <= sw, and digit_idx increments.
- IDLE:
  - ent captures digit 0, sets digit_idx=1, goes to ENTRY.
  - clr, lock and change are ignored.
- ENTRY:
  - ent captures a digit.
  - If the captured digit is at index NUM_DIGITS-1, go to CHECK; digit_idx wraps to 0.
  - clr clears entry_buf and digit_idx, goes to IDLE; fail_cnt is unchanged.
- CHECK (exactly one cycle, all inputs ignored):
  - If entry_buf == code: go to OPEN, fail_cnt=0, ok_p=1.
  - Else err_p=1 and fail_cnt increments. If the new fail_cnt == MAX_TRIES, go to LOCKOUT with timer=LOCKOUT_CYCLES-1; otherwise go to IDLE.
  - entry_buf clears on exit in either case.
- OPEN:
  - lock goes to IDLE.
  - change goes to NEW with digit_idx=0.
  - ent and clr are ignored.
- NEW:
  - Same capture rule as ENTRY.
  - On the last digit: code <= full entered value (last digit taken from sw), ok_p=1, go to OPEN, entry_buf cleared.
  - clr clears entry_buf and goes to OPEN; code is unchanged.
- LOCKOUT:
  - All strobes are ignored.
  - Timer decrements each cycle. On the cycle timer==0: go to IDLE, fail_cnt=0.
  - Total dwell is exactly LOCKOUT_CYCLES cycles.
- Outputs are registered. unlocked and locked_out are decoded from the state register, so they change in the same cycle as state.
- Reset mid-entry or mid-change discards the partial entry and restores DEFAULT_CODE.
- A changed code persists across lock/unlock and is lost only on reset.

Optional Feature:
- Macro: DIGIT_LOCK_CONFIRM_EN.
- Defined:
  - Completing NEW stores the entered value in a pending register and goes to CONFIRM with digit_idx=0; the code is not yet written.
  - CONFIRM captures digits the same way. On the last digit:
    - Match with pending: commit the code, ok_p=1, go to OPEN.
    - Mismatch: discard pending, err_p=1, go to OPEN with the code unchanged.
  - clr in CONFIRM discards pending and goes to OPEN.
- Undefined:
  - The CONFIRM state and pending register are absent.
  - NEW commits directly.
  - State encoding 5 is never produced.

Test Plan (NUM_DIGITS=4, DIGIT_W=4, MAX_TRIES=3, LOCKOUT_CYCLES=16, DEFAULT_CODE=16'h1234):
- Unlock: ent with sw=1,2,3,4 -> CHECK for 1 cycle, then OPEN; unlocked=1, ok_p single pulse, fail_cnt=0.
- Partial entry plus clr: ent 1,2 then clr -> IDLE, entry_buf=0, digit_idx=0; a following 1,2,3,4 entry unlocks.
- Lockout: three entries of 1,1,1,1 -> err_p x3, fail_cnt 1,2,3, then LOCKOUT with locked_out=1 for exactly 16 cycles. An ent during that window has no effect. Then IDLE with fail_cnt=0.
- Code change: unlock, change, ent 9,8,7,6 -> OPEN with ok_p. Then lock -> IDLE. Then 1,2,3,4 fails and 9,8,7,6 unlocks.
- Confirm (macro defined): change, 5,5,5,5, then 5,5,5,6 -> err_p, OPEN; code remains 16'h1234.
- Reset: assert rst low mid-NEW after 2 digits -> IDLE, code=16'h1234, all outputs 0 on the next cycle.
